// File: rtl/onehot_ring_enc.sv
// Parametrised one-hot ring counter with built-in binary encoder.
// Supports up/down stepping, synchronous index load, a wrap pulse and a sticky illegal-load flag.
module onehot_ring_enc #(
  parameter  int unsigned N         = 16,
  parameter  int unsigned RESET_IDX = 0,
  localparam int unsigned W         = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         EN,
  input  logic         DIR,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_IDX,
  output logic [0:N-1] Q,
  output logic [W-1:0] C,
  output logic         WRAP,
  output logic         ERR
);

  // Stage 0 sits in the leftmost bit, so shifting right walks toward higher stage indices.
  localparam logic [0:N-1] Q_TOP = {1'b1, {(N-1){1'b0}}};
  localparam logic [0:N-1] Q_RST = Q_TOP >> RESET_IDX;
  localparam logic [W:0]   N_EXT = (W+1)'(N);

  logic [0:N-1] q;
  logic [0:N-1] q_nxt;
  logic         wrap_q;
  logic         wrap_nxt;
  logic         err_q;
  logic         err_nxt;
  logic         load_ok;
  logic [0:N-1] load_vec;
  logic [0:N-1] q_up;
  logic [0:N-1] q_dn;

  assign load_ok  = ({1'b0, LOAD_IDX} < N_EXT);
  assign load_vec = Q_TOP >> LOAD_IDX;
  assign q_up     = {q[N-1], q[0:N-2]};
  assign q_dn     = {q[1:N-1], q[0]};

  // Next-state selection: load beats enable; an out-of-range load only flags.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    err_nxt  = err_q;
    if (LOAD) begin
      if (load_ok) begin
        q_nxt   = load_vec;
        err_nxt = 1'b0;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (EN) begin
      if (!DIR) begin
        q_nxt    = q_up;
        wrap_nxt = q[N-1];
      end else begin
        q_nxt    = q_dn;
        wrap_nxt = q[0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q      <= Q_RST;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q      <= q_nxt;
      wrap_q <= wrap_nxt;
      err_q  <= err_nxt;
    end
  end

  // OR-coder: each hot stage contributes its own index; one-hot Q leaves exactly one term.
  logic [W-1:0] enc_acc [N+1];
  assign enc_acc[0] = '0;
  for (genvar i = 0; i < N; i++) begin : g_enc
    assign enc_acc[i+1] = enc_acc[i] | (q[i] ? W'(i) : '0);
  end

  assign Q    = q;
  assign C    = enc_acc[N];
  assign WRAP = wrap_q;
  assign ERR  = err_q;

endmodule
